// File: rtl/mem_port_arb.sv
// Purpose : round-robin arbiter sharing one single-port memory (comb read, clocked write) among NREQ requesters.
// Latency : grant and memory drive are combinational; read data registered, rvalid one cycle after the grant.
// Backpress: an ungranted requester holds its request; a locked owner blocks every other requester.
// Optional : define ARB_PERF_CNT_EN to build per-requester saturating 16-bit grant counters.
module mem_port_arb #(
   parameter  int W     = 9,
   parameter  int DEPTH = 512,
   parameter  int NREQ  = 2,
   localparam int AW    = $clog2(DEPTH),
   localparam int PW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic [NREQ-1:0]      req_i,
   input  logic [NREQ-1:0]      we_i,
   input  logic [NREQ-1:0]      lock_i,
   input  logic [NREQ*AW-1:0]   addr_i,
   input  logic [NREQ*W-1:0]    wdata_i,
   output logic [NREQ-1:0]      gnt_o,
   output logic [NREQ-1:0]      rvalid_o,
   output logic [W-1:0]         rdata_o,
   output logic                 mem_we_o,
   output logic [AW-1:0]        mem_raddr_o,
   output logic [AW-1:0]        mem_waddr_o,
   output logic [W-1:0]         mem_wdata_o,
   input  logic [W-1:0]         mem_rdata_i,
   output logic [NREQ*16-1:0]   gnt_cnt_o
);

   typedef enum logic {
      ST_ARB   = 1'b0,
      ST_OWNED = 1'b1
   } state_e;

   state_e          state_q, state_d;
   logic [PW-1:0]   ptr_q, ptr_d;
   logic [PW-1:0]   owner_q, owner_d;
   logic [PW-1:0]   sel, cand;
   logic            found;
   logic            act;
   logic            rd_pend_q, rd_pend_d;
   logic [PW-1:0]   rd_id_q, rd_id_d;
   logic [W-1:0]    rdata_q, rdata_d;

   logic [AW-1:0]   addr_a  [NREQ];
   logic [W-1:0]    wdata_a [NREQ];

   // Unpack the flattened per-requester buses.
   for (genvar g = 0; g < NREQ; g++) begin : g_unpack
      assign addr_a[g]  = addr_i[g*AW +: AW];
      assign wdata_a[g] = wdata_i[g*W +: W];
   end

   function automatic logic [PW-1:0] inc_mod(input logic [PW-1:0] x);
      return PW'((int'(x) + 1) % NREQ);
   endfunction

   // Arbitration: round-robin search from ptr when free, owner-only service when locked.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      owner_d = owner_q;
      found   = 1'b0;
      sel     = '0;
      cand    = '0;
      case (state_q)
         ST_ARB: begin
            for (int k = 0; k < NREQ; k++) begin
               cand = PW'((int'(ptr_q) + k) % NREQ);
               if (!found && req_i[cand]) begin
                  found = 1'b1;
                  sel   = cand;
               end
            end
            if (found) begin
               if (lock_i[sel]) begin
                  state_d = ST_OWNED;
                  owner_d = sel;
               end else begin
                  ptr_d = inc_mod(sel);
               end
            end
         end
         ST_OWNED: begin
            sel = owner_q;
            if (req_i[owner_q]) begin
               found = 1'b1;
               // Last access of the burst: hand priority to the next requester.
               if (!lock_i[owner_q]) begin
                  state_d = ST_ARB;
                  ptr_d   = inc_mod(owner_q);
               end
            end else begin
               // Owner walked away without an access: release, others arbitrate next cycle.
               state_d = ST_ARB;
               ptr_d   = inc_mod(owner_q);
            end
         end
         default: state_d = ST_ARB;
      endcase
   end

   // A grant is suppressed while reset is asserted so nothing reaches the memory.
   assign act = rst_ni & found;

   // Drive grant and memory port from the selected requester; idle values are all zero.
   always_comb begin
      gnt_o       = '0;
      mem_we_o    = 1'b0;
      mem_raddr_o = '0;
      mem_waddr_o = '0;
      mem_wdata_o = '0;
      if (act) begin
         gnt_o[sel]  = 1'b1;
         mem_we_o    = we_i[sel];
         mem_raddr_o = addr_a[sel];
         mem_waddr_o = addr_a[sel];
         mem_wdata_o = wdata_a[sel];
      end
   end

   // Capture read data for a granted read; remember who gets the response.
   always_comb begin
      rd_pend_d = act & ~we_i[sel];
      rd_id_d   = sel;
      rdata_d   = rdata_q;
      if (rd_pend_d) begin
         rdata_d = mem_rdata_i;
      end
   end

   // Arbitration and read-response state.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= ST_ARB;
         ptr_q     <= '0;
         owner_q   <= '0;
         rd_pend_q <= 1'b0;
         rd_id_q   <= '0;
         rdata_q   <= '0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         owner_q   <= owner_d;
         rd_pend_q <= rd_pend_d;
         rd_id_q   <= rd_id_d;
         rdata_q   <= rdata_d;
      end
   end

   // One-cycle read-valid pulse routed to the requester that issued the read.
   always_comb begin
      rvalid_o = '0;
      if (rd_pend_q) begin
         rvalid_o[rd_id_q] = 1'b1;
      end
   end

   assign rdata_o = rdata_q;

`ifdef ARB_PERF_CNT_EN
   logic [15:0] cnt_q [NREQ];
   logic [15:0] cnt_d [NREQ];

   // Saturating count of completed transfers per requester.
   always_comb begin
      for (int i = 0; i < NREQ; i++) begin
         cnt_d[i] = cnt_q[i];
         if (req_i[i] && gnt_o[i] && (cnt_q[i] != 16'hFFFF)) begin
            cnt_d[i] = cnt_q[i] + 16'd1;
         end
      end
   end

   // Counter registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < NREQ; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NREQ; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   for (genvar g = 0; g < NREQ; g++) begin : g_cnt_out
      assign gnt_cnt_o[g*16 +: 16] = cnt_q[g];
   end
`else
   assign gnt_cnt_o = '0;
`endif

endmodule

// File: tb/tb_mem_port_arb.sv
// Bench for mem_port_arb: directed scenarios plus randomized traffic against a queue/array-level model.
// Latency: model predicts combinational grant/memory drive and a one-cycle read response.
// Backpressure: random requesters hold their transaction until granted, occasionally dropping it.
module tb_mem_port_arb;
   localparam int W     = 9;
   localparam int DEPTH = 512;
   localparam int NREQ  = 2;
   localparam int AW    = 9;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic [NREQ-1:0]      req, we, lock;
   logic [NREQ*AW-1:0]   addr;
   logic [NREQ*W-1:0]    wdata;
   logic [NREQ-1:0]      gnt, rvalid;
   logic [W-1:0]         rdata;
   logic                 mem_we;
   logic [AW-1:0]        mem_raddr, mem_waddr;
   logic [W-1:0]         mem_wdata, mem_rdata;
   logic [NREQ*16-1:0]   gnt_cnt;

   logic [W-1:0] mem       [DEPTH];
   logic [W-1:0] model_mem [DEPTH];
   assign mem_rdata = mem[mem_raddr];

   always #5 clk = ~clk;

   mem_port_arb #(.W(W), .DEPTH(DEPTH), .NREQ(NREQ)) dut (
      .clk_i(clk), .rst_ni(rst_n), .req_i(req), .we_i(we), .lock_i(lock),
      .addr_i(addr), .wdata_i(wdata), .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata),
      .mem_we_o(mem_we), .mem_raddr_o(mem_raddr), .mem_waddr_o(mem_waddr),
      .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata), .gnt_cnt_o(gnt_cnt)
   );

   int errors = 0;
   int checks = 0;

   // requester transactions
   bit            t_act  [NREQ];
   bit            t_we   [NREQ];
   bit            t_lock [NREQ];
   logic [AW-1:0] t_addr [NREQ];
   logic [W-1:0]  t_wd   [NREQ];

   // model state
   int              m_ptr, m_owner, m_g;
   bit              m_locked;
   logic [NREQ-1:0] m_rv;
   logic [W-1:0]    m_rdata;
   int              m_cnt [NREQ];

   // last sampled DUT values
   logic [NREQ-1:0] o_gnt, o_rv;
   logic [W-1:0]    o_rdata;
   logic            o_we;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_ptr = 0; m_owner = 0; m_locked = 0; m_rv = '0; m_rdata = '0; m_g = -1;
      for (int i = 0; i < NREQ; i++) m_cnt[i] = 0;
   endtask

   task automatic apply();
      for (int i = 0; i < NREQ; i++) begin
         req[i]  = t_act[i];
         we[i]   = t_we[i];
         lock[i] = t_lock[i];
         addr[i*AW +: AW] = t_addr[i];
         wdata[i*W +: W]  = t_wd[i];
      end
   endtask

   task automatic set_tx(input int i, input bit a, input bit w, input bit l, input int ad, input int wd);
      t_act[i] = a; t_we[i] = w; t_lock[i] = l; t_addr[i] = AW'(ad); t_wd[i] = W'(wd);
   endtask

   task automatic clear_tx();
      for (int i = 0; i < NREQ; i++) set_tx(i, 0, 0, 0, 0, 0);
   endtask

   function automatic int model_pick();
      if (m_locked) return req[m_owner] ? m_owner : -1;
      for (int k = 0; k < NREQ; k++) begin
         if (req[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
      end
      return -1;
   endfunction

   // One clock: check outputs at negedge against the model, advance model, land memory write.
   task automatic cycle();
      int              g;
      logic [NREQ-1:0] eg;
      logic            wr_en;
      logic [AW-1:0]   wa, ga;
      logic [W-1:0]    wd, gd;
      @(negedge clk);
      g = model_pick();
      m_g = g;
      o_gnt = gnt; o_rv = rvalid; o_rdata = rdata; o_we = mem_we;
      eg = '0;
      ga = '0;
      gd = '0;
      if (g >= 0) begin
         eg[g] = 1'b1;
         ga = addr[g*AW +: AW];
         gd = wdata[g*W +: W];
      end
      chk("gnt", gnt, eg);
      chk("mem_we", mem_we, (g >= 0) ? we[g] : 1'b0);
      chk("mem_raddr", mem_raddr, ga);
      chk("mem_waddr", mem_waddr, ga);
      chk("mem_wdata", mem_wdata, gd);
      chk("rvalid", rvalid, m_rv);
      chk("rdata", rdata, m_rdata);
      for (int i = 0; i < NREQ; i++) begin
`ifdef ARB_PERF_CNT_EN
         chk("gnt_cnt", gnt_cnt[i*16 +: 16], m_cnt[i]);
`else
         chk("gnt_cnt", gnt_cnt[i*16 +: 16], 0);
`endif
      end
      wr_en = mem_we; wa = mem_waddr; wd = mem_wdata;
      // advance model
      m_rv = '0;
      if (g >= 0) begin
         if (we[g]) model_mem[ga] = gd;
         else begin
            m_rv[g] = 1'b1;
            m_rdata = model_mem[ga];
         end
         if (m_cnt[g] < 65535) m_cnt[g]++;
      end
      if (!m_locked) begin
         if (g >= 0) begin
            if (lock[g]) begin m_locked = 1; m_owner = g; end
            else m_ptr = (g + 1) % NREQ;
         end
      end else if (!(req[m_owner] && lock[m_owner])) begin
         m_locked = 0;
         m_ptr = (m_owner + 1) % NREQ;
      end
      @(posedge clk);
      if (wr_en) mem[wa] = wd;
      #1;
   endtask

   // Reset with live requests (forced-zero checks), release, return at posedge+1.
   task automatic do_reset();
      rst_n = 1'b0;
      for (int i = 0; i < NREQ; i++) set_tx(i, 1, (i == 0), 0, i, 3);
      apply();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_gnt", gnt, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_rvalid", rvalid, 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_gnt_cnt", gnt_cnt, 0);
      clear_tx();
      apply();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      model_reset();
   endtask

   task automatic new_tx(input int i);
      set_tx(i, $urandom_range(0, 9) < 7, $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0,
             $urandom_range(0, 15), $urandom);
   endtask

   initial begin
      for (int a = 0; a < DEPTH; a++) begin
         mem[a] = W'($urandom);
         model_mem[a] = mem[a];
      end
      clear_tx();
      apply();
      model_reset();
      do_reset();

      // 1: alternating reads
      mem[5] = 9'h00A; model_mem[5] = 9'h00A;
      mem[9] = 9'h01F; model_mem[9] = 9'h01F;
      set_tx(0, 1, 0, 0, 5, 0);
      set_tx(1, 1, 0, 0, 9, 0);
      apply();
      cycle(); chk("t1_gnt_c0", o_gnt, 2'b01);
      cycle(); chk("t1_gnt_c1", o_gnt, 2'b10); chk("t1_rv_c1", o_rv, 2'b01); chk("t1_rd_c1", o_rdata, 9'h00A);
      cycle(); chk("t1_gnt_c2", o_gnt, 2'b01); chk("t1_rv_c2", o_rv, 2'b10); chk("t1_rd_c2", o_rdata, 9'h01F);
      cycle(); chk("t1_rd_c3", o_rdata, 9'h00A);

      // 2: write then read same address
      do_reset();
      set_tx(0, 1, 1, 0, 3, 9'h155);
      apply();
      cycle(); chk("t2_we", o_we, 1); chk("t2_gnt0", o_gnt, 2'b01);
      clear_tx(); set_tx(1, 1, 0, 0, 3, 0); apply();
      cycle(); chk("t2_gnt1", o_gnt, 2'b10);
      clear_tx(); apply();
      cycle(); chk("t2_rv", o_rv, 2'b10); chk("t2_rd", o_rdata, 9'h155);

      // 3: locked burst of four reads by requester 1
      do_reset();
      set_tx(1, 1, 0, 1, 10, 0);
      apply();
      cycle(); chk("t3_gnt_a10", o_gnt, 2'b10);
      set_tx(0, 1, 0, 0, 0, 0);
      for (int a = 11; a <= 13; a++) begin
         set_tx(1, 1, 0, a != 13, a, 0);
         apply();
         cycle(); chk("t3_gnt_burst", o_gnt, 2'b10);
      end
      set_tx(1, 1, 0, 0, 20, 0);
      apply();
      cycle(); chk("t3_release_gnt0", o_gnt, 2'b01);
      clear_tx(); apply();
      cycle(); chk("t3_gnt1_after", o_gnt, 2'b00);

      // 4: locked owner drops req with lock still high
      do_reset();
      set_tx(1, 1, 0, 1, 7, 0);
      apply();
      cycle(); chk("t4_gnt_own", o_gnt, 2'b10);
      set_tx(1, 0, 0, 1, 7, 0);
      set_tx(0, 1, 1, 0, 8, 9'h0AA);
      apply();
      cycle(); chk("t4_gnt_rel", o_gnt, 2'b00); chk("t4_we_rel", o_we, 0);
      cycle(); chk("t4_gnt_next", o_gnt, 2'b01); chk("t4_we_next", o_we, 1);
      clear_tx(); apply();
      cycle();

      // 5: async reset during a read grant cycle
      set_tx(0, 1, 0, 0, 5, 0);
      apply();
      #2;
      chk("t5_pre_gnt", gnt, 2'b01);
      rst_n = 1'b0;
      #1;
      chk("t5_gnt", gnt, 0); chk("t5_we", mem_we, 0); chk("t5_rv", rvalid, 0);
      @(posedge clk); #1;
      chk("t5_rv_after", rvalid, 0); chk("t5_rd_after", rdata, 0);
      set_tx(1, 1, 0, 0, 9, 0);
      apply();
      @(posedge clk); #1;
      chk("t5_rv_held", rvalid, 0);
      rst_n = 1'b1;
      model_reset();
      cycle(); chk("t5_first_gnt", o_gnt, 2'b01);

      // randomized traffic
      for (int i = 0; i < NREQ; i++) new_tx(i);
      repeat (3000) begin
         apply();
         cycle();
         for (int i = 0; i < NREQ; i++) begin
            if (m_g == i) begin
               if (m_locked && m_owner == i)
                  set_tx(i, $urandom_range(0, 9) < 9, $urandom_range(0, 2) == 0, $urandom_range(0, 1),
                         $urandom_range(0, 15), $urandom);
               else new_tx(i);
            end else if (t_act[i]) begin
               if ($urandom_range(0, 19) == 0) t_act[i] = 0;
            end else if ($urandom_range(0, 2) == 0) begin
               new_tx(i);
            end
         end
      end
      clear_tx(); apply();
      cycle();

`ifdef ARB_PERF_CNT_EN
      // 6: saturation of requester 0 counter
      do_reset();
      set_tx(0, 1, 0, 0, 5, 0);
      apply();
      repeat (70000) cycle();
      chk("t6_cnt0_sat", gnt_cnt[15:0], 16'hFFFF);
      chk("t6_cnt1_zero", gnt_cnt[31:16], 0);
`else
      chk("t6_cnt_off", gnt_cnt, 0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
